// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the clock period meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF     = 100_000_000;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizes an asynchronous input into clk and flags its rising edge.
module sig_sync_edge
    import clk_meas_pkg::*;
#(
    parameter int unsigned sync_stages = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    generate
        if (sync_stages < 2) begin : g_bad_stages
            $error("sig_sync_edge: sync_stages must be at least 2");
        end
    endgenerate

    logic [sync_stages-1:0] sync_q;
    logic                   p;

    // Synchronizer chain plus one extra flop holding the previous synchronized level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            p      <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], sig_in};
            p      <= sync_q[sync_stages-1];
        end
    end

    assign s    = sync_q[sync_stages-1];
    assign rise = s & ~p;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles; results leave
// through a valid/ready port with overrun and loss-of-signal flags.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned cnt_w       = CNT_W_DEF,
    parameter int unsigned sync_stages = SYNC_STAGES_DEF,
    parameter int unsigned timeout_val = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             sig_in,
    input  logic             clr_flags,
    output logic [cnt_w-1:0] period,
    output logic [cnt_w-1:0] high_time,
    output logic             valid,
    input  logic             ready,
    output logic             ovf,
    output logic             lost
);

    // The counter must reach timeout_val without wrapping.
    generate
        if (timeout_val == 0 || (timeout_val >> cnt_w) != 0) begin : g_bad_timeout
            $error("clk_period_meter: timeout_val must be in 1 .. 2**cnt_w-1");
        end
    endgenerate

    localparam logic [cnt_w-1:0] TIMEOUT_CNT = cnt_w'(timeout_val);
    localparam logic [cnt_w-1:0] ONE         = cnt_w'(1);

    state_t           state, state_d;
    logic [cnt_w-1:0] cnt, cnt_d;
    logic [cnt_w-1:0] hi, hi_d;
    logic [cnt_w-1:0] period_d, high_time_d;
    logic             valid_d, ovf_d, lost_d;
    logic             new_res_c;
    logic             s, rise;

    sig_sync_edge #(
        .sync_stages(sync_stages)
    ) u_sync (
        .clk   (clk),
        .rstn  (rstn),
        .sig_in(sig_in),
        .s     (s),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hi        <= hi_d;
            period    <= period_d;
            high_time <= high_time_d;
            valid     <= valid_d;
            ovf       <= ovf_d;
            lost      <= lost_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        hi_d        = hi;
        lost_d      = lost;
        new_res_c   = 1'b0;
        period_d    = period;
        high_time_d = high_time;
        valid_d     = valid;
        ovf_d       = ovf;

        case (state)
            IDLE: begin
                cnt_d = '0;
                hi_d  = '0;
                if (en) state_d = ALIGN;
            end
            // ALIGN still counts so a dead input is reported as lost.
            ALIGN: begin
                if (rise) begin
                    cnt_d   = ONE;
                    hi_d    = ONE;
                    lost_d  = 1'b0;
                    state_d = MEASURE;
                end else if (cnt == TIMEOUT_CNT) begin
                    cnt_d  = '0;
                    lost_d = 1'b1;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    new_res_c = 1'b1;
                    cnt_d     = ONE;
                    hi_d      = ONE;
                    lost_d    = 1'b0;
                end else if (cnt == TIMEOUT_CNT) begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    lost_d  = 1'b1;
                    state_d = ALIGN;
                end else begin
                    cnt_d = cnt + ONE;
                    hi_d  = hi + cnt_w'(s);
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable discards any partial measurement.
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hi_d      = '0;
            lost_d    = lost;
            new_res_c = 1'b0;
        end

        if (valid && ready) valid_d = 1'b0;
        if (clr_flags) ovf_d = 1'b0;

        // A result arriving while the previous one is still unconsumed is dropped.
        if (new_res_c) begin
            if (!valid || ready) begin
                period_d    = cnt;
                high_time_d = hi;
                valid_d     = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized scoreboard bench for clk_period_meter: the model derives each expected
// result from the waveform segments driven onto sig_in.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int unsigned CW = 32;
    localparam int unsigned SS = 2;
    localparam int unsigned TO = 200;

    typedef struct packed {
        logic [CW-1:0] p;
        logic [CW-1:0] h;
    } res_t;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          en        = 1'b0;
    logic          sig_in    = 1'b0;
    logic          clr_flags = 1'b0;
    logic          ready     = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          ovf;
    logic          lost;

    clk_period_meter #(
        .cnt_w      (CW),
        .sync_stages(SS),
        .timeout_val(TO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .sig_in   (sig_in),
        .clr_flags(clr_flags),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .ready    (ready),
        .ovf      (ovf),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    // Model state: cycles and high cycles since the last rising edge driven.
    bit          armed   = 1'b0;
    int unsigned since   = 0;
    int unsigned hi_acc  = 0;
    bit          stall   = 1'b0;
    bit          held    = 1'b0;
    int unsigned dropped = 0;

    // 0 random (never low 3 cycles running), 1 held low, 2 held high, 3 single pulse
    int          ready_mode = 0;
    int unsigned ready_at   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input int unsigned p, input int unsigned h);
        res_t r;
        if (stall && held) begin
            dropped++;
        end else begin
            r.p = CW'(p);
            r.h = CW'(h);
            exp_q.push_back(r);
            if (stall) held = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        since++;
        if (sig_in) hi_acc++;
    endtask

    // Hold sig_in at lvl for n cycles; a rising edge closes the previous period.
    task automatic seg(input bit lvl, input int unsigned n);
        if (lvl && !sig_in) begin
            if (armed && en && since <= TO) push(since, hi_acc);
            armed  = en;
            since  = 0;
            hi_acc = 0;
        end
        sig_in = lvl;
        repeat (n) tick();
    endtask

    task automatic set_en(input bit v);
        en = v;
        if (!v) armed = 1'b0;
    endtask

    // Ready driver
    initial begin
        int low_run;
        low_run = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: begin
                    if (low_run >= 2 || $urandom_range(3, 0) != 0) begin
                        ready   = 1'b1;
                        low_run = 0;
                    end else begin
                        ready = 1'b0;
                        low_run++;
                    end
                end
                1:       ready = 1'b0;
                2:       ready = 1'b1;
                default: ready = (cyc + 1 == ready_at);
            endcase
        end
    end

    // Monitor: every accepted result must match the head of the scoreboard.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rstn && valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got period=%0d high=%0d expected none",
                             period, high_time);
                end else begin
                    r = exp_q.pop_front();
                    chk("period", 64'(period), 64'(r.p));
                    chk("high_time", 64'(high_time), 64'(r.h));
                end
            end
        end
    end

    initial begin
        int unsigned k0;
        int unsigned e_cyc;
        int unsigned h;
        int unsigned l;
        int unsigned n;
        bit          seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_period", 64'(period), 64'd0);
        chk("rst_high", 64'(high_time), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_lost", 64'(lost), 64'd0);
        rstn = 1'b1;
        tick();

        // Test 1: div_val=9 source, ready high
        ready_mode = 2;
        set_en(1'b1);
        repeat (6) begin
            seg(1'b1, 5);
            seg(1'b0, 5);
        end

        // Test 2: period 100 with ready low for three results
        seg(1'b1, 50);
        seg(1'b0, 40);
        chk("drained_before_stall", 64'(exp_q.size()), 64'd0);
        stall      = 1'b1;
        held       = 1'b0;
        dropped    = 0;
        ready_mode = 1;
        seg(1'b0, 10);
        repeat (3) begin
            seg(1'b1, 50);
            seg(1'b0, 50);
        end
        chk("held_valid", 64'(valid), 64'd1);
        chk("held_period", 64'(period), 64'd100);
        chk("held_high", 64'(high_time), 64'd50);
        chk("ovf_set", 64'(ovf), 64'(dropped > 0));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovf_cleared", 64'(ovf), 64'd0);
        stall      = 1'b0;
        held       = 1'b0;
        ready_mode = 2;
        repeat (3) tick();

        // Test 3: new result lands on the same cycle the old one is consumed
        ready_mode = 1;
        chk("idle_before_t3", 64'(valid), 64'd0);
        fork
            begin
                repeat (4) begin
                    seg(1'b1, 10);
                    seg(1'b0, 10);
                end
            end
            begin
                seen = 1'b0;
                n    = 0;
                while (!seen && n < 100) begin
                    @(posedge clk);
                    #2;
                    seen = valid;
                    n++;
                end
                if (!seen) begin
                    total++;
                    bad++;
                    $display("FAIL t3_wait_valid: got no result expected one within 100 cycles");
                end else begin
                    e_cyc      = cyc;
                    ready_at   = e_cyc + 20;
                    ready_mode = 3;
                    while (cyc < e_cyc + 20) begin
                        @(posedge clk);
                        #2;
                    end
                    chk("t3_valid_stays", 64'(valid), 64'd1);
                    chk("t3_new_period", 64'(period), 64'd20);
                    chk("t3_no_ovf", 64'(ovf), 64'd0);
                    ready_mode = 2;
                end
            end
        join
        ready_mode = 2;

        // Test 4: input stops after a rise; lost asserts exactly at the timeout
        k0 = cyc;
        seg(1'b1, 10);
        seg(1'b0, k0 + SS + TO - cyc);
        chk("lost_before_timeout", 64'(lost), 64'd0);
        seg(1'b0, 1);
        chk("lost_at_timeout", 64'(lost), 64'd1);
        chk("no_result_on_timeout", 64'(valid), 64'd0);
        seg(1'b1, 8);
        chk("lost_cleared_by_rise", 64'(lost), 64'd0);
        seg(1'b0, 12);
        repeat (3) begin
            seg(1'b1, 8);
            seg(1'b0, 12);
        end

        // Test 5: enable dropped mid-period and re-raised
        ready_mode = 0;
        seg(1'b1, 8);
        seg(1'b0, 5);
        set_en(1'b0);
        seg(1'b0, 5);
        seg(1'b1, 8);
        seg(1'b0, 5);
        set_en(1'b1);
        seg(1'b0, 5);
        seg(1'b1, 7);
        chk("no_result_after_reenable", 64'(valid), 64'd0);
        seg(1'b0, 9);
        seg(1'b1, 7);
        seg(1'b0, 9);

        // Test 6: asynchronous reset while a result is held and ovf is set
        chk("drained_before_t6", 64'(exp_q.size()), 64'd0);
        stall      = 1'b1;
        held       = 1'b0;
        dropped    = 0;
        ready_mode = 1;
        repeat (2) begin
            seg(1'b1, 10);
            seg(1'b0, 10);
        end
        seg(1'b1, 10);
        seg(1'b0, 5);
        chk("t6_valid_before_rst", 64'(valid), 64'd1);
        chk("t6_ovf_before_rst", 64'(ovf), 64'(dropped > 0));
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(valid), 64'd0);
        chk("t6_rst_period", 64'(period), 64'd0);
        chk("t6_rst_high", 64'(high_time), 64'd0);
        chk("t6_rst_ovf", 64'(ovf), 64'd0);
        chk("t6_rst_lost", 64'(lost), 64'd0);
        exp_q.delete();
        armed  = 1'b0;
        stall  = 1'b0;
        held   = 1'b0;
        tick();
        tick();
        rstn       = 1'b1;
        ready_mode = 2;
        seg(1'b0, 5);
        seg(1'b1, 6);
        seg(1'b0, 6);
        chk("t6_no_result_first_rise", 64'(valid), 64'd0);
        seg(1'b1, 6);
        seg(1'b0, 6);

        // Randomized periods, duty cycles, ready stalls and enable toggles
        ready_mode = 0;
        repeat (40) begin
            h = $urandom_range(70, 2);
            l = $urandom_range(70, 4);
            seg(1'b1, h);
            if (l >= 8 && $urandom_range(7, 0) == 0) begin
                seg(1'b0, l / 2);
                set_en(!en);
                seg(1'b0, l - l / 2);
            end else begin
                seg(1'b0, l);
            end
        end
        set_en(1'b1);
        seg(1'b1, 10);
        seg(1'b0, 10);
        seg(1'b1, 10);
        seg(1'b0, 20);
        ready_mode = 2;
        repeat (5) tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_valid", 64'(valid), 64'd0);
        chk("final_ovf", 64'(ovf), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
